// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS-Extended control FSM with shared memory port, Z/N/V status and counters
module multicycle_ctrl #(
  parameter int          COUNT_W     = 32,
  parameter logic [5:0]  FUNCT_BALRZ = 6'h16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               alu_zero,
  input  logic               alu_neg,
  input  logic               alu_ovf,
  input  logic               mem_ready,
  output logic               pcwrite,
  output logic               pcwritecond,
  output logic               iord,
  output logic               memread,
  output logic               memwrite,
  output logic               irwrite,
  output logic               regwrite,
  output logic               regdst,
  output logic [1:0]         memtoreg,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         aluop,
  output logic [1:0]         pcsource,
  output logic               status_z,
  output logic               status_n,
  output logic               status_v,
  output logic               illegal,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] cycle_count,
  output logic [COUNT_W-1:0] instr_count
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3, MEM_WB = 4'd4, MEM_WRITE = 4'd5,
    EXEC_R = 4'd6, R_WB = 4'd7, BRANCH = 4'd8, BALRZ = 4'd9, TRAP = 4'd10, RESET = 4'd11
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       regdst;
    logic [1:0] memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       pcwritecond;
    logic [1:0] pcsource;
  } ctrl_t;

  state_t               state_q, state_d;
  ctrl_t                ctrl_q, ctrl_d;
  logic [2:0]           flags_q, flags_d;
  logic                 illegal_q, illegal_d;
  logic [COUNT_W-1:0]   cycle_q, cycle_d, instr_q, instr_d;
  logic                 retire;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:     begin c.memread = 1'b1; c.alusrcb = 2'd1; end
      DECODE:    c.alusrcb = 2'd3;
      MEM_ADDR:  begin c.alusrca = 1'b1; c.alusrcb = 2'd2; end
      MEM_READ:  begin c.memread = 1'b1; c.iord = 1'b1; end
      MEM_WB:    begin c.regwrite = 1'b1; c.memtoreg = 2'd1; end
      MEM_WRITE: begin c.memwrite = 1'b1; c.iord = 1'b1; end
      EXEC_R:    begin c.alusrca = 1'b1; c.aluop = 2'b10; end
      R_WB:      begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      BRANCH:    begin c.alusrca = 1'b1; c.aluop = 2'b01; c.pcwritecond = 1'b1; c.pcsource = 2'd1; end
      BALRZ:     begin c.regwrite = 1'b1; c.regdst = 1'b1; c.memtoreg = 2'd2; c.pcsource = 2'd2; end
      default:   c = '0;
    endcase
    return c;
  endfunction

  // Next state, status capture on EXEC_R exit, counters, and controls pre-decoded from the next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      RESET:     state_d = FETCH;
      FETCH:     state_d = mem_ready ? DECODE : FETCH;
      DECODE:    case (opcode)
                   6'h23, 6'h2b: state_d = MEM_ADDR;
                   6'h04:        state_d = BRANCH;
                   6'h00:        state_d = (funct == FUNCT_BALRZ) ? BALRZ : EXEC_R;
                   default:      state_d = TRAP;
                 endcase
      MEM_ADDR:  state_d = (opcode == 6'h23) ? MEM_READ : MEM_WRITE;
      MEM_READ:  state_d = mem_ready ? MEM_WB : MEM_READ;
      MEM_WRITE: state_d = mem_ready ? FETCH : MEM_WRITE;
      EXEC_R:    state_d = R_WB;
      TRAP:      state_d = TRAP;
      default:   state_d = FETCH;
    endcase
    retire    = (state_d == FETCH) && (state_q inside {MEM_WB, MEM_WRITE, R_WB, BRANCH, BALRZ});
    flags_d   = (state_q == EXEC_R) ? {alu_zero, alu_neg, alu_ovf} : flags_q;
    cycle_d   = (state_q != RESET && state_q != TRAP) ? cycle_q + COUNT_W'(1) : cycle_q;
    instr_d   = retire ? instr_q + COUNT_W'(1) : instr_q;
    illegal_d = illegal_q || (state_d == TRAP);
    ctrl_d    = decode(state_d);
  end

  // State register with registered Moore controls; reset kills every strobe immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RESET;
      ctrl_q    <= '0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
      cycle_q   <= '0;
      instr_q   <= '0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
      cycle_q   <= cycle_d;
      instr_q   <= instr_d;
    end
  end

  assign irwrite     = (state_q == FETCH) && mem_ready;
  assign pcwrite     = irwrite || ((state_q == BALRZ) && flags_q[2]);
  assign pcwritecond = ctrl_q.pcwritecond;
  assign iord        = ctrl_q.iord;
  assign memread     = ctrl_q.memread;
  assign memwrite    = ctrl_q.memwrite;
  assign regwrite    = ctrl_q.regwrite;
  assign regdst      = ctrl_q.regdst;
  assign memtoreg    = ctrl_q.memtoreg;
  assign alusrca     = ctrl_q.alusrca;
  assign alusrcb     = ctrl_q.alusrcb;
  assign aluop       = ctrl_q.aluop;
  assign pcsource    = ctrl_q.pcsource;
  assign {status_z, status_n, status_v} = flags_q;
  assign illegal     = illegal_q;
  assign state       = state_q;
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: instruction-level model of the multi-cycle controller checked every cycle
module tb_multicycle_ctrl;
  logic        clk, rst_n;
  logic [5:0]  opcode, funct;
  logic        alu_zero, alu_neg, alu_ovf, mem_ready;
  logic        pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regwrite, regdst, alusrca;
  logic [1:0]  memtoreg, alusrcb, aluop, pcsource;
  logic        status_z, status_n, status_v, illegal;
  logic [3:0]  state;
  logic [31:0] cycle_count, instr_count;

  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .alu_neg(alu_neg), .alu_ovf(alu_ovf), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite), .regdst(regdst),
    .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsource(pcsource), .status_z(status_z), .status_n(status_n), .status_v(status_v),
    .illegal(illegal), .state(state), .cycle_count(cycle_count), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0, n_fail = 0;
  logic        chk;
  int          e_state;
  logic [16:0] e_ctrl;
  logic        m_z, m_n, m_v;
  logic [31:0] m_cyc, m_ins;
  logic [16:0] ctrl_vec;

  assign ctrl_vec = {pcwrite, pcwritecond, iord, memread, memwrite, irwrite, regwrite, regdst,
                     memtoreg, alusrca, alusrcb, aluop, pcsource};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Control table per state as listed in the datasheet, order matches ctrl_vec
  function automatic logic [16:0] spec_ctrl(input int st, input logic rdy, input logic z);
    logic pw, pwc, io, mr, mw, ir, rw, rd, as;
    logic [1:0] mtr, bs, op, ps;
    {pw, pwc, io, mr, mw, ir, rw, rd, as} = '0;
    mtr = 2'd0; bs = 2'd0; op = 2'd0; ps = 2'd0;
    case (st)
      0:  begin mr = 1; bs = 2'd1; pw = rdy; ir = rdy; end
      1:  bs = 2'd3;
      2:  begin as = 1; bs = 2'd2; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; mtr = 2'd1; end
      5:  begin mw = 1; io = 1; end
      6:  begin as = 1; op = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin as = 1; op = 2'b01; pwc = 1; ps = 2'd1; end
      9:  begin rw = 1; rd = 1; mtr = 2'd2; pw = z; ps = 2'd2; end
      default: ;
    endcase
    return {pw, pwc, io, mr, mw, ir, rw, rd, mtr, as, bs, op, ps};
  endfunction

  always @(negedge clk) if (chk) begin
    check("state", {28'd0, state}, e_state);
    check("ctrl", {15'd0, ctrl_vec}, {15'd0, e_ctrl});
    check("flags", {29'd0, status_z, status_n, status_v}, {29'd0, m_z, m_n, m_v});
    check("illegal", {31'd0, illegal}, {31'd0, e_state == 10});
    check("cycle_count", cycle_count, m_cyc);
    check("instr_count", instr_count, m_ins);
  end

  task automatic step(input int st, input logic rdy);
    mem_ready = rdy;
    e_state = st;
    e_ctrl = spec_ctrl(st, rdy, m_z);
    chk = 1'b1;
    @(posedge clk); #1;
    if (st != 10 && st != 11) m_cyc++;
  endtask

  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw, input logic [2:0] fl);
    opcode = op; funct = fn; {alu_zero, alu_neg, alu_ovf} = fl;
    repeat (fw) step(0, 0);
    step(0, 1);
    step(1, 0);
    if (op == 6'h23) begin
      step(2, 0); repeat (mw) step(3, 0); step(3, 1); step(4, 0); m_ins++;
    end else if (op == 6'h2b) begin
      step(2, 0); repeat (mw) step(5, 0); step(5, 1); m_ins++;
    end else if (op == 6'h04) begin
      step(8, 0); m_ins++;
    end else if (op == 6'h00 && fn == 6'h16) begin
      step(9, 1); m_ins++;
    end else if (op == 6'h00) begin
      step(6, 1); {m_z, m_n, m_v} = fl; step(7, 0); m_ins++;
    end else begin
      repeat (4) step(10, 1);
    end
  endtask

  task automatic model_reset();
    {m_z, m_n, m_v} = 3'b000; m_cyc = 0; m_ins = 0;
  endtask

  initial begin
    rst_n = 0; opcode = 0; funct = 0; {alu_zero, alu_neg, alu_ovf} = 3'b000; mem_ready = 0; chk = 0;
    e_state = 11; e_ctrl = '0; model_reset();
    repeat (2) @(posedge clk); #1;
    check("rst_state", {28'd0, state}, 32'd11);
    check("rst_ctrl", {15'd0, ctrl_vec}, 32'd0);
    check("rst_cycle", cycle_count, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    rst_n = 1;
    step(11, 1);
    instr(6'h00, 6'h20, 0, 0, 3'b000);
    check("add_cycles", cycle_count, 32'd4);
    check("add_instr", instr_count, 32'd1);
    instr(6'h23, 6'h00, 0, 3, 3'b000);
    check("lw_cycles", cycle_count, 32'd12);
    instr(6'h00, 6'h22, 0, 0, 3'b100);
    check("sub_z", {31'd0, status_z}, 32'd1);
    instr(6'h00, 6'h16, 0, 0, 3'b000);
    check("balrz1_cycles", cycle_count, 32'd19);
    instr(6'h00, 6'h22, 0, 0, 3'b010);
    instr(6'h00, 6'h16, 0, 0, 3'b000);
    instr(6'h04, 6'h00, 0, 0, 3'b111);
    check("beq_flags", {29'd0, status_z, status_n, status_v}, 32'b010);
    check("beq_cycles", cycle_count, 32'd29);
    instr(6'h2b, 6'h00, 1, 2, 3'b000);
    check("sw_cycles", cycle_count, 32'd36);
    check("sw_instr", instr_count, 32'd8);
    instr(6'h3f, 6'h00, 0, 0, 3'b000);
    check("trap_illegal", {31'd0, illegal}, 32'd1);
    check("trap_cycles", cycle_count, 32'd38);
    check("trap_instr", instr_count, 32'd8);
    chk = 0;
    rst_n = 0; #1;
    check("trap_rst_illegal", {31'd0, illegal}, 32'd0);
    check("trap_rst_state", {28'd0, state}, 32'd11);
    @(posedge clk); #1;
    rst_n = 1; model_reset();
    step(11, 1);
    opcode = 6'h2b; funct = 0;
    step(0, 1); step(1, 1); step(2, 1); step(5, 0); step(5, 0);
    chk = 0; #2;
    check("wr_hold", {31'd0, memwrite}, 32'd1);
    rst_n = 0; #1;
    check("wr_rst_memwrite", {31'd0, memwrite}, 32'd0);
    check("wr_rst_state", {28'd0, state}, 32'd11);
    check("wr_rst_cycle", cycle_count, 32'd0);
    check("wr_rst_instr", instr_count, 32'd0);
    @(posedge clk); #1;
    rst_n = 1; model_reset();
    step(11, 1);
    instr(6'h00, 6'h20, 0, 0, 3'b001);
    check("post_rst_cycles", cycle_count, 32'd4);
    check("post_rst_instr", instr_count, 32'd1);
    chk = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
